// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the reset PC default, the control-state encodings and a
// word-alignment helper used on the next-PC path.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Instructions are word-aligned; any low address bit set is a fault.
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a req/ack handshake, holds inst until consumed.
// Latency: 2 cycles per instruction minimum; each memory-wait or downstream-stall cycle adds one.
// Backpressure: inst_ready low holds inst/inst_pc/pc stable and blocks the next request.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  input  logic [31:0]      npc,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  input  logic             inst_ready,
  output logic             fault,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t state, state_nxt;
  logic   capture;   // memory word accepted this cycle
  logic   consume;   // downstream takes the held instruction this cycle

  // The fetch address is always the PC; it only matters while imem_req is high.
  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs; ack/ready only steer transitions.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    consume    = 1'b0;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          consume   = 1'b1;
          state_nxt = misaligned(npc) ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_BOOT;
    endcase
  end

  // Datapath: capture on ack, advance PC and retire count on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      fault      <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (capture) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      if (consume) begin
        pc         <= npc;
        retire_cnt <= retire_cnt + CNT_W'(1);
        if (misaligned(npc)) fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// memory latency, stalls and branch targets against a transaction model.
module tb_fetch_unit;

  localparam logic [31:0] EXP_RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fault;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: architectural PC, retired count, fault flag.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fault;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .npc        (npc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .fault      (fault),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold reset for n edges with stray ack/ready traffic, then release into boot.
  task automatic do_reset(input int n);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b1;
    npc        = $urandom;
    repeat (n) step();
    m_pc    = EXP_RESET_PC;
    m_cnt   = 0;
    m_fault = 1'b0;
    chk("rst_pc",      pc,                 EXP_RESET_PC);
    chk("rst_inst",    inst,               32'h0);
    chk("rst_inst_pc", inst_pc,            32'h0);
    chk("rst_fault",   {31'h0, fault},     32'h0);
    chk("rst_cnt",     retire_cnt,         32'h0);
    chk("rst_req",     {31'h0, imem_req},  32'h0);
    chk("rst_valid",   {31'h0, inst_valid},32'h0);
    // Late ack arrives during the boot settle cycle and must be ignored.
    rst = 1'b0;
    step();
    imem_ack = 1'b0;
    chk("boot_inst",  inst,               32'h0);
    chk("boot_valid", {31'h0, inst_valid},32'h0);
  endtask

  // Memory answers after `waits` idle cycles; ready/npc noise must be ignored.
  task automatic fetch_phase(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      inst_ready = 1'($urandom);
      npc        = $urandom;
      chk("wait_req",   {31'h0, imem_req},  32'h1);
      chk("wait_addr",  imem_addr,          m_pc);
      chk("wait_valid", {31'h0, inst_valid},32'h0);
      chk("wait_pc",    pc,                 m_pc);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    inst_ready = 1'($urandom);
    npc        = $urandom;
    chk("ack_req",   {31'h0, imem_req},  32'h1);
    chk("ack_addr",  imem_addr,          m_pc);
    chk("ack_valid", {31'h0, inst_valid},32'h0);
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Downstream stalls `stall` cycles (with stray acks), then consumes with npc=nxt.
  task automatic issue_phase(input int stall, input logic [31:0] data, input logic [31:0] nxt);
    for (int s = 0; s < stall; s++) begin
      inst_ready = 1'b0;
      imem_ack   = 1'($urandom);
      npc        = $urandom;
      chk("stall_valid",   {31'h0, inst_valid},32'h1);
      chk("stall_inst",    inst,               data);
      chk("stall_inst_pc", inst_pc,            m_pc);
      chk("stall_pc",      pc,                 m_pc);
      chk("stall_req",     {31'h0, imem_req},  32'h0);
      chk("stall_cnt",     retire_cnt,         m_cnt);
      step();
    end
    inst_ready = 1'b1;
    imem_ack   = 1'b0;
    npc        = nxt;
    chk("issue_valid",   {31'h0, inst_valid},32'h1);
    chk("issue_inst",    inst,               data);
    chk("issue_inst_pc", inst_pc,            m_pc);
    step();
    inst_ready = 1'b0;
    npc        = $urandom;
    m_cnt      = m_cnt + 1;
    m_pc       = nxt;
    if (nxt[1:0] != 2'b00) m_fault = 1'b1;
    chk("post_pc",    pc,                 m_pc);
    chk("post_cnt",   retire_cnt,         m_cnt);
    chk("post_fault", {31'h0, fault},     {31'h0, m_fault});
    chk("post_req",   {31'h0, imem_req},  {31'h0, !m_fault});
    chk("post_valid", {31'h0, inst_valid},32'h0);
  endtask

  task automatic one_instr(input int waits, input int stall, input logic [31:0] nxt);
    logic [31:0] d;
    d = $urandom;
    fetch_phase(waits, d);
    issue_phase(stall, d, nxt);
  endtask

  initial begin
    logic [31:0] tgt;
    logic [31:0] d;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; npc = '0;
    m_pc = EXP_RESET_PC; m_cnt = 0; m_fault = 1'b0;
    step();
    do_reset(2);

    // Zero-wait memory, always-ready consumer: 0x3000, 0x3004, 0x3008.
    for (int i = 0; i < 3; i++) one_instr(0, 0, m_pc + 32'd4);
    chk("three_retired", retire_cnt, 32'd3);

    // Slow memory, then a long downstream stall.
    one_instr(3, 0, m_pc + 32'd4);
    one_instr(0, 5, m_pc + 32'd4);

    // Taken branch to 0x3040; following fetch must come from there.
    one_instr(1, 1, 32'h0000_3040);
    one_instr(0, 0, m_pc + 32'd4);

    // Reset while an instruction is held: discarded, count not bumped.
    d = $urandom;
    fetch_phase(0, d);
    do_reset(1);

    // Randomized latency, stalls and aligned branch targets.
    for (int i = 0; i < 40; i++) begin
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      one_instr($urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? tgt : m_pc + 32'd4);
    end
    chk("rand_cnt", retire_cnt, 32'd40);

    // Reset during fetch with ack on the same and the following edge.
    do_reset(2);
    one_instr(0, 0, m_pc + 32'd4);

    // Misaligned next PC: sticky fault, everything quiet until reset.
    one_instr(0, 2, 32'h0000_3042);
    for (int i = 0; i < 6; i++) begin
      imem_ack   = 1'($urandom);
      inst_ready = 1'($urandom);
      npc        = $urandom;
      step();
      chk("fault_hold",  {31'h0, fault},     32'h1);
      chk("fault_req",   {31'h0, imem_req},  32'h0);
      chk("fault_valid", {31'h0, inst_valid},32'h0);
      chk("fault_pc",    pc,                 32'h0000_3042);
      chk("fault_cnt",   retire_cnt,         m_cnt);
    end
    do_reset(1);
    one_instr(0, 0, m_pc + 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
